// File: rtl/latency_bin_monitor.sv
// Passive per-channel latency monitor: timestamps each c_miss, matches it to the
// next in-order mm_rd, bins the latency into a saturating histogram and flags protocol errors.
module latency_bin_monitor #(
  parameter int NUM_CH    = 2,
  parameter int NUM_BINS  = 8,
  parameter int BIN_WIDTH = 16,
  parameter int MAX_OUT   = 4,
  parameter int TS_W      = 16,
  parameter int CNT_W     = 16,
  parameter int TIMEOUT   = 1000
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_CH-1:0]                     c_miss,
  input  logic [NUM_CH-1:0]                     mm_rd,
  input  logic                                  clr,
  input  logic [$clog2(NUM_CH)-1:0]             rd_ch,
  input  logic [$clog2(NUM_BINS)-1:0]           rd_bin,
  output logic [CNT_W-1:0]                      rd_count,
  output logic [NUM_CH-1:0]                     lat_valid,
  output logic [NUM_CH*TS_W-1:0]                lat_value,
  output logic [NUM_CH*$clog2(MAX_OUT+1)-1:0]   outstanding,
  output logic [NUM_CH-1:0]                     ovf_err,
  output logic [NUM_CH-1:0]                     orphan_err,
  output logic [NUM_CH-1:0]                     timeout_err
);
  localparam int OCC_W = $clog2(MAX_OUT + 1);
  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int SHIFT = $clog2(BIN_WIDTH);
  localparam int BIN_W = $clog2(NUM_BINS);

  logic [TS_W-1:0]   ts_q, ts_d;
  logic [TS_W-1:0]   fifo_q      [NUM_CH][MAX_OUT];
  logic [TS_W-1:0]   fifo_d      [NUM_CH][MAX_OUT];
  logic [PTR_W-1:0]  head_q      [NUM_CH];
  logic [PTR_W-1:0]  head_d      [NUM_CH];
  logic [PTR_W-1:0]  tail_q      [NUM_CH];
  logic [PTR_W-1:0]  tail_d      [NUM_CH];
  logic [OCC_W-1:0]  occ_q       [NUM_CH];
  logic [OCC_W-1:0]  occ_d       [NUM_CH];
  logic [CNT_W-1:0]  bins_q      [NUM_CH][NUM_BINS];
  logic [CNT_W-1:0]  bins_d      [NUM_CH][NUM_BINS];
  logic [TS_W-1:0]   lat_value_q [NUM_CH];
  logic [TS_W-1:0]   lat_value_d [NUM_CH];
  logic [NUM_CH-1:0] lat_valid_q, lat_valid_d;
  logic [NUM_CH-1:0] ovf_q, ovf_d, orphan_q, orphan_d, timeout_q, timeout_d;
  logic [CNT_W-1:0]  rd_count_q, rd_count_d;

  logic [TS_W-1:0]   age     [NUM_CH];
  logic [BIN_W-1:0]  bin_idx [NUM_CH];
  logic [NUM_CH-1:0] empty, full, do_pop, do_push;

  // Age of each head entry doubles as the latency when that entry is popped.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      age[c]     = ts_q - fifo_q[c][head_q[c]];
      bin_idx[c] = ((age[c] >> SHIFT) >= TS_W'(NUM_BINS - 1)) ? BIN_W'(NUM_BINS - 1)
                                                                : BIN_W'(age[c] >> SHIFT);
      empty[c]   = (occ_q[c] == '0);
      full[c]    = (occ_q[c] == OCC_W'(MAX_OUT));
      do_pop[c]  = mm_rd[c] && !empty[c];
      do_push[c] = c_miss[c] && (!full[c] || do_pop[c]);
    end
  end

  always_comb begin
    ts_d        = ts_q + TS_W'(1);
    fifo_d      = fifo_q;
    head_d      = head_q;
    tail_d      = tail_q;
    occ_d       = occ_q;
    bins_d      = bins_q;
    lat_value_d = lat_value_q;
    lat_valid_d = '0;
    ovf_d       = ovf_q;
    orphan_d    = orphan_q;
    timeout_d   = timeout_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!empty[c] && (age[c] >= TS_W'(TIMEOUT))) timeout_d[c] = 1'b1;
      if (mm_rd[c] && empty[c]) orphan_d[c] = 1'b1;
      if (c_miss[c] && !do_push[c]) ovf_d[c] = 1'b1;
      if (do_pop[c]) begin
        lat_valid_d[c] = 1'b1;
        lat_value_d[c] = age[c];
        if (bins_q[c][bin_idx[c]] != {CNT_W{1'b1}})
          bins_d[c][bin_idx[c]] = bins_q[c][bin_idx[c]] + CNT_W'(1);
        head_d[c] = (head_q[c] == PTR_W'(MAX_OUT - 1)) ? '0 : head_q[c] + PTR_W'(1);
      end
      if (do_push[c]) begin
        fifo_d[c][tail_q[c]] = ts_q;
        tail_d[c] = (tail_q[c] == PTR_W'(MAX_OUT - 1)) ? '0 : tail_q[c] + PTR_W'(1);
      end
      occ_d[c] = occ_q[c] + OCC_W'(do_push[c]) - OCC_W'(do_pop[c]);
    end
    // Clear overrides any same-cycle increment or flag set.
    if (clr) begin
      bins_d    = '{default: '0};
      ovf_d     = '0;
      orphan_d  = '0;
      timeout_d = '0;
    end
    rd_count_d = '0;
    if ((int'(rd_ch) < NUM_CH) && (int'(rd_bin) < NUM_BINS))
      rd_count_d = bins_q[rd_ch][rd_bin];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q        <= '0;
      fifo_q      <= '{default: '0};
      head_q      <= '{default: '0};
      tail_q      <= '{default: '0};
      occ_q       <= '{default: '0};
      bins_q      <= '{default: '0};
      lat_value_q <= '{default: '0};
      lat_valid_q <= '0;
      ovf_q       <= '0;
      orphan_q    <= '0;
      timeout_q   <= '0;
      rd_count_q  <= '0;
    end else begin
      ts_q        <= ts_d;
      fifo_q      <= fifo_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      occ_q       <= occ_d;
      bins_q      <= bins_d;
      lat_value_q <= lat_value_d;
      lat_valid_q <= lat_valid_d;
      ovf_q       <= ovf_d;
      orphan_q    <= orphan_d;
      timeout_q   <= timeout_d;
      rd_count_q  <= rd_count_d;
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      lat_value[c*TS_W +: TS_W]     = lat_value_q[c];
      outstanding[c*OCC_W +: OCC_W] = occ_q[c];
    end
  end

  assign lat_valid   = lat_valid_q;
  assign ovf_err     = ovf_q;
  assign orphan_err  = orphan_q;
  assign timeout_err = timeout_q;
  assign rd_count    = rd_count_q;

endmodule

// File: tb/tb_latency_bin_monitor.sv
// Bench for latency_bin_monitor: queue-based reference model on a default instance,
// plus a small-parameter instance (TS_W=8, CNT_W=2, TIMEOUT=50) for wrap/timeout/saturation.
module tb_latency_bin_monitor;
  localparam int NUM_CH    = 2;
  localparam int NUM_BINS  = 8;
  localparam int BIN_WIDTH = 16;
  localparam int MAX_OUT   = 4;
  localparam int TS_W      = 16;
  localparam int CNT_W     = 16;
  localparam int TIMEOUT   = 1000;
  localparam int OCC_W     = 3;
  localparam int TS_MOD    = 65536;
  localparam int CNT_MAX   = 65535;

  logic       clk = 1'b0;
  logic       rst, clr;
  logic [1:0] c_miss, mm_rd;
  logic       rd_ch;
  logic [2:0] rd_bin;

  logic [CNT_W-1:0]        rd_count;
  logic [1:0]              lat_valid, ovf_err, orphan_err, timeout_err;
  logic [2*TS_W-1:0]       lat_value;
  logic [2*OCC_W-1:0]      outstanding;

  logic [1:0]              rd_count_s;
  logic [1:0]              lat_valid_s, ovf_err_s, orphan_err_s, timeout_err_s;
  logic [15:0]             lat_value_s;
  logic [2*OCC_W-1:0]      outstanding_s;

  always #5 clk = ~clk;

  latency_bin_monitor dut (
    .clk(clk), .rst(rst), .c_miss(c_miss), .mm_rd(mm_rd), .clr(clr),
    .rd_ch(rd_ch), .rd_bin(rd_bin), .rd_count(rd_count), .lat_valid(lat_valid),
    .lat_value(lat_value), .outstanding(outstanding), .ovf_err(ovf_err),
    .orphan_err(orphan_err), .timeout_err(timeout_err)
  );

  latency_bin_monitor #(.TS_W(8), .CNT_W(2), .TIMEOUT(50)) dut_s (
    .clk(clk), .rst(rst), .c_miss(c_miss), .mm_rd(mm_rd), .clr(clr),
    .rd_ch(rd_ch), .rd_bin(rd_bin), .rd_count(rd_count_s), .lat_valid(lat_valid_s),
    .lat_value(lat_value_s), .outstanding(outstanding_s), .ovf_err(ovf_err_s),
    .orphan_err(orphan_err_s), .timeout_err(timeout_err_s)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: one queue of request timestamps per channel.
  int unsigned mq [NUM_CH][$];
  int          m_bins [NUM_CH][NUM_BINS];
  bit          m_ovf [NUM_CH], m_orph [NUM_CH], m_tout [NUM_CH], m_valid [NUM_CH];
  int          m_val [NUM_CH];
  int          m_ts, m_rd;

  typedef struct {
    int ch;
    int lat;
    int exp_bin;
  } lat_vec_t;

  lat_vec_t vecs [9];
  int       exp_cnt [NUM_CH][NUM_BINS];

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      mq[c].delete();
      for (int b = 0; b < NUM_BINS; b++) m_bins[c][b] = 0;
      m_ovf[c] = 0; m_orph[c] = 0; m_tout[c] = 0; m_valid[c] = 0; m_val[c] = 0;
    end
    m_ts = 0;
    m_rd = 0;
  endtask

  task automatic model_step();
    int lat, b;
    m_rd = m_bins[rd_ch][rd_bin];
    for (int c = 0; c < NUM_CH; c++) begin
      m_valid[c] = 0;
      if (mq[c].size() > 0 && ((m_ts - int'(mq[c][0]) + TS_MOD) % TS_MOD) >= TIMEOUT) m_tout[c] = 1;
      if (mm_rd[c]) begin
        if (mq[c].size() == 0) m_orph[c] = 1;
        else begin
          lat = (m_ts - int'(mq[c].pop_front()) + TS_MOD) % TS_MOD;
          m_valid[c] = 1;
          m_val[c] = lat;
          b = lat / BIN_WIDTH;
          if (b > NUM_BINS - 1) b = NUM_BINS - 1;
          if (m_bins[c][b] < CNT_MAX) m_bins[c][b]++;
        end
      end
      if (c_miss[c]) begin
        if (mq[c].size() < MAX_OUT) mq[c].push_back(m_ts);
        else m_ovf[c] = 1;
      end
    end
    if (clr) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int b2 = 0; b2 < NUM_BINS; b2++) m_bins[c][b2] = 0;
        m_ovf[c] = 0; m_orph[c] = 0; m_tout[c] = 0;
      end
    end
    m_ts = (m_ts + 1) % TS_MOD;
  endtask

  task automatic compare_model();
    for (int c = 0; c < NUM_CH; c++) begin
      check_output($sformatf("ch%0d lat_valid", c), 64'(lat_valid[c]), 64'(m_valid[c]));
      if (m_valid[c]) check_output($sformatf("ch%0d lat_value", c), 64'(lat_value[c*TS_W +: TS_W]), 64'(m_val[c]));
      check_output($sformatf("ch%0d outstanding", c), 64'(outstanding[c*OCC_W +: OCC_W]), 64'(mq[c].size()));
      check_output($sformatf("ch%0d ovf_err", c), 64'(ovf_err[c]), 64'(m_ovf[c]));
      check_output($sformatf("ch%0d orphan_err", c), 64'(orphan_err[c]), 64'(m_orph[c]));
      check_output($sformatf("ch%0d timeout_err", c), 64'(timeout_err[c]), 64'(m_tout[c]));
    end
    check_output("rd_count", 64'(rd_count), 64'(m_rd));
  endtask

  // One clock: drive, let the DUT sample, advance the model, compare on the falling edge.
  task automatic apply_stimulus(input logic [1:0] miss, input logic [1:0] resp,
                                input logic clear, input logic reset_in);
    c_miss = miss; mm_rd = resp; clr = clear; rst = reset_in;
    @(posedge clk);
    if (reset_in) model_reset(); else model_step();
    @(negedge clk);
    compare_model();
    c_miss = '0; mm_rd = '0; clr = 1'b0; rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(2'b00, 2'b00, 1'b0, 1'b0);
  endtask

  initial begin
    c_miss = '0; mm_rd = '0; clr = 1'b0; rst = 1'b1; rd_ch = 1'b0; rd_bin = '0;
    vecs[0] = '{1, 11, 0};  vecs[1] = '{1, 40, 2};  vecs[2] = '{1, 101, 6};
    vecs[3] = '{1, 200, 7}; vecs[4] = '{0, 15, 0};  vecs[5] = '{0, 16, 1};
    vecs[6] = '{0, 111, 6}; vecs[7] = '{0, 112, 7}; vecs[8] = '{0, 1, 0};
    @(negedge clk);

    $display("[TB] reset state");
    apply_stimulus(2'b00, 2'b00, 1'b0, 1'b1);
    check_output("reset lat_valid", 64'(lat_valid), 64'd0);
    check_output("reset outstanding", 64'(outstanding), 64'd0);
    check_output("reset rd_count", 64'(rd_count), 64'd0);

    $display("[TB] single latency of 11 on ch0");
    apply_stimulus(2'b01, 2'b00, 1'b0, 1'b0);
    idle(10);
    apply_stimulus(2'b00, 2'b01, 1'b0, 1'b0);
    check_output("t1 lat_valid", 64'(lat_valid[0]), 64'd1);
    check_output("t1 lat_value", 64'(lat_value[15:0]), 64'd11);
    rd_ch = 1'b0; rd_bin = 3'd0;
    idle(1);
    check_output("t1 bin0", 64'(rd_count), 64'd1);
    apply_stimulus(2'b01, 2'b00, 1'b0, 1'b0);
    idle(10);
    apply_stimulus(2'b00, 2'b01, 1'b1, 1'b0);
    idle(1);
    check_output("clr beats increment", 64'(rd_count), 64'd0);

    $display("[TB] latency table");
    apply_stimulus(2'b00, 2'b00, 1'b0, 1'b1);
    for (int c = 0; c < NUM_CH; c++) for (int b = 0; b < NUM_BINS; b++) exp_cnt[c][b] = 0;
    foreach (vecs[i]) begin
      apply_stimulus(2'(1 << vecs[i].ch), 2'b00, 1'b0, 1'b0);
      idle(vecs[i].lat - 1);
      apply_stimulus(2'b00, 2'(1 << vecs[i].ch), 1'b0, 1'b0);
      check_output($sformatf("vec%0d lat_valid", i), 64'(lat_valid[vecs[i].ch]), 64'd1);
      check_output($sformatf("vec%0d lat_value", i), 64'(lat_value[vecs[i].ch*TS_W +: TS_W]), 64'(vecs[i].lat));
      exp_cnt[vecs[i].ch][vecs[i].exp_bin]++;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      for (int b = 0; b < NUM_BINS; b++) begin
        rd_ch = c[0]; rd_bin = b[2:0];
        idle(1);
        check_output($sformatf("table ch%0d bin%0d", c, b), 64'(rd_count), 64'(exp_cnt[c][b]));
      end
    end

    $display("[TB] orphan responses and clear");
    apply_stimulus(2'b00, 2'b00, 1'b0, 1'b1);
    apply_stimulus(2'b00, 2'b01, 1'b0, 1'b0);
    check_output("orphan flag", 64'(orphan_err[0]), 64'd1);
    check_output("orphan no valid", 64'(lat_valid[0]), 64'd0);
    apply_stimulus(2'b00, 2'b00, 1'b1, 1'b0);
    check_output("orphan cleared", 64'(orphan_err[0]), 64'd0);
    apply_stimulus(2'b01, 2'b01, 1'b0, 1'b0);
    check_output("same-cycle empty orphan", 64'(orphan_err[0]), 64'd1);
    check_output("same-cycle empty push", 64'(outstanding[2:0]), 64'd1);

    $display("[TB] overflow and in-order completion");
    apply_stimulus(2'b00, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) apply_stimulus(2'b01, 2'b00, 1'b0, 1'b0);
    check_output("ovf flag", 64'(ovf_err[0]), 64'd1);
    check_output("ovf outstanding", 64'(outstanding[2:0]), 64'd4);
    idle(15);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(2'b00, 2'b01, 1'b0, 1'b0);
      check_output($sformatf("ovf lat%0d", i), 64'(lat_value[15:0]), 64'd20);
    end
    rd_ch = 1'b0; rd_bin = 3'd1;
    idle(1);
    check_output("ovf bin1", 64'(rd_count), 64'd4);

    $display("[TB] timestamp wrap on 8-bit instance");
    apply_stimulus(2'b00, 2'b00, 1'b0, 1'b1);
    idle(250);
    apply_stimulus(2'b01, 2'b00, 1'b0, 1'b0);
    idle(10);
    apply_stimulus(2'b00, 2'b01, 1'b0, 1'b0);
    check_output("wrap lat_valid", 64'(lat_valid_s[0]), 64'd1);
    check_output("wrap lat_value", 64'(lat_value_s[7:0]), 64'd11);

    $display("[TB] timeout and reset mid-wait");
    apply_stimulus(2'b00, 2'b00, 1'b0, 1'b1);
    apply_stimulus(2'b01, 2'b00, 1'b0, 1'b0);
    idle(49);
    check_output("timeout age49", 64'(timeout_err_s[0]), 64'd0);
    idle(1);
    check_output("timeout age50", 64'(timeout_err_s[0]), 64'd1);
    apply_stimulus(2'b00, 2'b00, 1'b0, 1'b1);
    check_output("timeout after rst", 64'(timeout_err_s[0]), 64'd0);
    check_output("outstanding after rst", 64'(outstanding_s[2:0]), 64'd0);
    apply_stimulus(2'b00, 2'b01, 1'b0, 1'b0);
    check_output("orphan after rst", 64'(orphan_err_s[0]), 64'd1);
    check_output("no valid after rst", 64'(lat_valid_s[0]), 64'd0);

    $display("[TB] saturation on 2-bit counters");
    apply_stimulus(2'b00, 2'b00, 1'b0, 1'b1);
    rd_ch = 1'b0; rd_bin = 3'd0;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(2'b01, 2'b00, 1'b0, 1'b0);
      idle(10);
      apply_stimulus(2'b00, 2'b01, 1'b0, 1'b0);
      idle(1);
      check_output($sformatf("sat hit%0d", i), 64'(rd_count_s), 64'((i < 3) ? i + 1 : 3));
    end

    $display("[TB] randomized traffic");
    apply_stimulus(2'b00, 2'b00, 1'b0, 1'b1);
    for (int n = 0; n < 1200; n++) begin
      int thr;
      logic [1:0] miss, resp;
      thr = (n < 600) ? 3 : 1;
      miss = {($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3)};
      resp = {($urandom_range(0, 9) < thr), ($urandom_range(0, 9) < thr)};
      rd_ch = 1'($urandom_range(0, 1));
      rd_bin = 3'($urandom_range(0, 7));
      apply_stimulus(miss, resp, ($urandom_range(0, 79) == 0), ($urandom_range(0, 399) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
